// File: rtl/reset_cond_pkg.sv
// Shared definitions for the push-button reset conditioner: FSM states and
// default debounce/stretch timing for a 50 MHz board clock.
package reset_cond_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    ASSERT      = 3'd2,
    DEB_RELEASE = 3'd3,
    STRETCH     = 3'd4
  } reset_cond_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned STRETCH_CYCLES_DEF  = 1024;
  localparam int unsigned CNT_W_DEF           = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input; RST_VAL sets
// the level both flops hold while rst_ni is low.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_button_conditioner.sv
// Synchronizes and debounces the board KEY into a registered active-low reset
// request. Define RESET_COND_STRETCH_EN to add the minimum-width stretch after release.
module reset_button_conditioner
  import reset_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned STRETCH_CYCLES  = STRETCH_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_i,
  output logic reset_n_o,
  output logic press_o
);

  if (DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES and STRETCH_CYCLES must be at least 1");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) || (64'd1 << CNT_W) <= 64'(STRETCH_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef RESET_COND_STRETCH_EN
  localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam reset_cond_state_e RST_STATE = STRETCH;
  localparam reset_cond_state_e REL_STATE = STRETCH;
`else
  localparam reset_cond_state_e RST_STATE = IDLE;
  localparam reset_cond_state_e REL_STATE = IDLE;
`endif

  logic btn_s;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_btn_sync (
    .clk_i  (clk_i),
    .rst_ni (reset_i),
    .d_i    (button_i),
    .q_o    (btn_s)
  );

  reset_cond_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              reset_n_q, reset_n_d;
  logic              press_q, press_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!btn_s) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ASSERT;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ASSERT: begin
        if (btn_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        if (!btn_s) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = REL_STATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef RESET_COND_STRETCH_EN
      STRETCH: begin
        // Button level is deliberately ignored until the pulse has its minimum width.
        if (cnt_q == STR_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Output comes from its own flop so the reset line never sees decode glitches.
    reset_n_d = (state_d == IDLE) || (state_d == DEB_PRESS);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      reset_n_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reset_n_q <= reset_n_d;
      press_q   <= press_d;
    end
  end

  assign reset_n_o = reset_n_q;
  assign press_o   = press_q;

endmodule

// File: tb/tb_reset_button_conditioner.sv
// Directed bench for reset_button_conditioner with DEBOUNCE_CYCLES=8,
// STRETCH_CYCLES=4, CNT_W=4; expectations follow RESET_COND_STRETCH_EN.
module tb_reset_button_conditioner;

`ifdef RESET_COND_STRETCH_EN
  localparam int PWR_RISE  = 4;   // edge after reset release where reset_n_o rises
  localparam int REL       = 14;  // edge after first high sample where reset_n_o rises
  localparam int HELD_FALL = 13;  // edge where a press held through reset is accepted
`else
  localparam int PWR_RISE  = 1;
  localparam int REL       = 10;
  localparam int HELD_FALL = 11;
`endif

  logic clk = 1'b0;
  logic reset_i;
  logic button_i;
  logic reset_n_o;
  logic press_o;

  int total = 0;
  int bad   = 0;

  reset_button_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .STRETCH_CYCLES  (4),
    .CNT_W           (4)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .button_i  (button_i),
    .reset_n_o (reset_n_o),
    .press_o   (press_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic btn;
    logic exp_rn;
    logic exp_pr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic b, logic rn, logic pr, int n);
    vec_t v;
    v.rst = r; v.btn = b; v.exp_rn = rn; v.exp_pr = pr;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic exp_rn, logic exp_pr);
    total++;
    if (reset_n_o !== exp_rn || press_o !== exp_pr) begin
      bad++;
      $display("FAIL %s idx=%0d reset_n_o=%b want=%b press_o=%b want=%b",
               name, idx, reset_n_o, exp_rn, press_o, exp_pr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i  = 1'b0;
    button_i = 1'b1;

    // power-on: reset low 5 cycles, then release
    add(0, 1, 0, 0, 5);
    add(1, 1, 0, 0, PWR_RISE - 1);
    add(1, 1, 1, 0, 3);
    // clean press
    add(1, 0, 1, 0, 10);
    add(1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 3);
    // clean release
    add(1, 1, 0, 0, REL);
    add(1, 1, 1, 0, 3);
    // bouncy press: 5 low, 1 high, then low held
    add(1, 0, 1, 0, 5);
    add(1, 1, 1, 0, 1);
    add(1, 0, 1, 0, 10);
    add(1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 2);
    // release with a single low bounce sample at edge 4
    add(1, 1, 0, 0, 4);
    add(1, 0, 0, 0, 1);
    add(1, 1, 0, 0, REL);
    add(1, 1, 1, 0, 3);

    foreach (vecs[i]) begin
      reset_i  = vecs[i].rst;
      button_i = vecs[i].btn;
      tick();
      check("table", i, vecs[i].exp_rn, vecs[i].exp_pr);
    end

    // async reset while in DEB_PRESS
    button_i = 1'b0;
    repeat (5) tick();
    check("mid_deb_press", 0, 1'b1, 1'b0);
    #3;
    reset_i = 1'b0;
    #1;
    check("async_assert", 0, 1'b0, 1'b0);
    button_i = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("async_hold", e, 1'b0, 1'b0);
    end
    reset_i = 1'b1;
    for (int e = 1; e <= PWR_RISE + 2; e++) begin
      tick();
      check("repower", e, logic'(e >= PWR_RISE), 1'b0);
    end

    // button held down through power-on reset
    reset_i  = 1'b0;
    button_i = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("held_rst", e, 1'b0, 1'b0);
    end
    reset_i = 1'b1;
    for (int e = 1; e <= HELD_FALL + 1; e++) begin
      tick();
      check("held_seq", e, logic'(e >= PWR_RISE && e < HELD_FALL), logic'(e == HELD_FALL));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
